// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: word RAM with byte enables plus an MMIO page
// (timer, LEDs, number display, switches). One-cycle read latency, read-before-write.
module data_sram_responder #(
  parameter int          ADDR_W  = 12,
  parameter logic [15:0] MMIO_HI = 16'hBFAF,
  parameter int          SW_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            data_sram_en,
  input  logic [3:0]      data_sram_wen,
  input  logic [31:0]     data_sram_addr,
  input  logic [31:0]     data_sram_wdata,
  output logic [31:0]     data_sram_rdata,
  input  logic [SW_W-1:0] switch_in,
  output logic [15:0]     led_out,
  output logic [31:0]     num_out
);

  localparam int          DEPTH      = 1 << ADDR_W;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;
  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_NUM    = 16'hF010;
  localparam logic [15:0] OFF_SWITCH = 16'hF02C;

  logic              is_mmio;
  logic [ADDR_W-1:0] ram_idx;
  logic [15:0]       mmio_off;
  logic              ram_acc;
  logic              mmio_wr;
  logic              unused_addr_bits;

  assign is_mmio          = (data_sram_addr[31:16] == MMIO_HI);
  assign ram_idx          = data_sram_addr[ADDR_W+1:2];
  assign mmio_off         = data_sram_addr[15:0];
  assign ram_acc          = data_sram_en && !is_mmio && !rst;
  assign mmio_wr          = data_sram_en && is_mmio && (data_sram_wen != 4'b0000);
  assign unused_addr_bits = ^data_sram_addr[1:0];

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // One narrow RAM per byte lane so each lane infers a plain block RAM with its own write enable.
  logic [31:0] ram_rd;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;
      always_ff @(posedge clk) begin
        if (ram_acc) begin
          rd_q <= mem[ram_idx];
          if (data_sram_wen[gi]) mem[ram_idx] <= data_sram_wdata[8*gi +: 8];
        end
      end
      assign ram_rd[8*gi +: 8] = rd_q;
    end
  endgenerate

  logic [31:0] timer_q, timer_d;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] mmio_rd_q, mmio_rd_d;
  logic        src_mmio_q, src_mmio_d;
  logic [31:0] mmio_rdval;

  always_comb begin
    mmio_rdval = '0;
    case (mmio_off)
      OFF_TIMER:  mmio_rdval = timer_q;
      OFF_LED:    mmio_rdval = {16'h0000, led_q};
      OFF_NUM:    mmio_rdval = num_q;
      OFF_SWITCH: mmio_rdval = 32'(switch_in);
      default:    mmio_rdval = '0;
    endcase
  end

  always_comb begin
    timer_d    = timer_q + 32'd1;
    led_d      = led_q;
    num_d      = num_q;
    mmio_rd_d  = mmio_rd_q;
    src_mmio_d = src_mmio_q;
    // The output mux source only moves on a real access so rdata holds while idle.
    if (data_sram_en) begin
      src_mmio_d = is_mmio;
      if (is_mmio) mmio_rd_d = mmio_rdval;
    end
    if (mmio_wr) begin
      case (mmio_off)
        OFF_TIMER: timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
        OFF_LED: begin
          if (data_sram_wen[0]) led_d[7:0]  = data_sram_wdata[7:0];
          if (data_sram_wen[1]) led_d[15:8] = data_sram_wdata[15:8];
        end
        OFF_NUM:   num_d = byte_merge(num_q, data_sram_wdata, data_sram_wen);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= '0;
      led_q      <= '0;
      num_q      <= '0;
      mmio_rd_q  <= '0;
      src_mmio_q <= 1'b1;
    end else begin
      timer_q    <= timer_d;
      led_q      <= led_d;
      num_q      <= num_d;
      mmio_rd_q  <= mmio_rd_d;
      src_mmio_q <= src_mmio_d;
    end
  end

  assign data_sram_rdata = src_mmio_q ? mmio_rd_q : ram_rd;
  assign led_out         = led_q;
  assign num_out         = num_q;

endmodule
